relm_fp_normalize: RTL and testbench

RELM_FP_NORMALIZE -- requirements
Module: relm_fp_normalize

---
 rtl/relm_fp_normalize.sv | 131 +++++++++++++
 tb/tb_relm_fp_normalize.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/relm_fp_normalize.sv
// Post-arithmetic normalizer/rounder for IEEE-754 single precision results.
// Rounding: define RELM_FPNORM_ROUND_EN for round-to-nearest-even, otherwise truncation.
module relm_fp_normalize #(
   parameter int WD = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [WD-1:0] in_m,
   input  logic [WD-1:0] in_b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [WD-1:0] out_f
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NORM  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_stateNext;
   logic               r_sign;
   logic               w_signNext;
   logic [WD-1:0]      r_m;
   logic [WD-1:0]      w_mNext;
   logic signed [9:0]  r_e;
   logic signed [9:0]  w_eNext;
   logic [WD-1:0]      r_f;
   logic [WD-1:0]      w_fNext;

   logic               w_inc;
   logic [23:0]        w_fSum;
   logic signed [9:0]  w_eRnd;
   logic               w_unused;

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign out_f     = r_f;
   assign w_unused  = &{1'b0, in_b[20:0]};

`ifdef RELM_FPNORM_ROUND_EN
   assign w_inc = r_m[6] & ((|r_m[5:0]) | r_m[7]);
`else
   assign w_inc = 1'b0;
`endif

   // Bit 23 of the sum is the fraction carry-out; the low 23 bits are already zero then.
   assign w_fSum = {1'b0, r_m[29:7]} + {23'd0, w_inc};
   assign w_eRnd = r_e + {9'd0, w_fSum[23]};

   always_comb begin
      w_stateNext = r_state;
      w_signNext  = r_sign;
      w_mNext     = r_m;
      w_eNext     = r_e;
      w_fNext     = r_f;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_signNext = in_b[31];
               w_mNext    = in_m;
               w_eNext    = {2'b00, in_b[30:23]};
               if (in_b[22]) begin
                  w_fNext     = {in_b[31], 8'hFF, 23'd0};
                  w_stateNext = DONE;
               end else if (in_b[21] || (in_m == '0)) begin
                  w_fNext     = {in_b[31], 31'd0};
                  w_stateNext = DONE;
               end else begin
                  w_stateNext = NORM;
               end
            end
         end
         NORM: begin
            if (r_m[31]) begin
               w_mNext     = {1'b0, r_m[31:2], r_m[1] | r_m[0]};
               w_eNext     = r_e + 10'sd1;
               w_stateNext = ROUND;
            end else if (r_m[30]) begin
               w_stateNext = ROUND;
            end else if (r_m[29:22] == 8'd0) begin
               w_mNext = {r_m[23:0], 8'd0};
               w_eNext = r_e - 10'sd8;
            end else begin
               w_mNext = {r_m[30:0], 1'b0};
               w_eNext = r_e - 10'sd1;
            end
         end
         ROUND: begin
            w_eNext = w_eRnd;
            if (w_eRnd >= 10'sd255) begin
               w_fNext = {r_sign, 8'hFF, 23'd0};
            end else if (w_eRnd <= 10'sd0) begin
               w_fNext = {r_sign, 31'd0};
            end else begin
               w_fNext = {r_sign, w_eRnd[7:0], w_fSum[22:0]};
            end
            w_stateNext = DONE;
         end
         DONE: begin
            if (out_ready) begin
               w_stateNext = IDLE;
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_sign  <= 1'b0;
         r_m     <= '0;
         r_e     <= '0;
         r_f     <= '0;
      end else begin
         r_state <= w_stateNext;
         r_sign  <= w_signNext;
         r_m     <= w_mNext;
         r_e     <= w_eNext;
         r_f     <= w_fNext;
      end
   end

endmodule

// File: tb/tb_relm_fp_normalize.sv
// Self-checking bench for relm_fp_normalize: directed corner vectors plus random
// operands checked against a leading-one based reference model.
module tb_relm_fp_normalize;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_m = '0;
   logic [31:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_f;

   int nChecks = 0;
   int nFails  = 0;

`ifdef RELM_FPNORM_ROUND_EN
   localparam bit RNE = 1'b1;
`else
   localparam bit RNE = 1'b0;
`endif

   relm_fp_normalize #(.WD(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_m      (in_m),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_f     (out_f)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] mkB(input logic s, input logic [7:0] ex,
                                       input logic inf, input logic zero);
      return {s, ex, inf, zero, 21'd0};
   endfunction

   // Reference: find the leading one, normalize in one step, round on a 24-bit significand.
   function automatic void refModel(input logic [31:0] m, input logic [31:0] b,
                                    output logic [31:0] f, output int lat);
      logic        s;
      int          e;
      int          p;
      int          k;
      int          cycles;
      logic [31:0] n;
      int          sig;
      logic [7:0]  eb;
      s = b[31];
      e = int'(b[30:23]);
      if (b[22]) begin
         f = {s, 8'hFF, 23'd0}; lat = 1; return;
      end
      if (b[21] || m == 32'd0) begin
         f = {s, 31'd0}; lat = 1; return;
      end
      p = 0;
      for (int i = 0; i < 32; i++) if (m[i]) p = i;
      if (p == 31) begin
         n = (m >> 1) | (m & 32'd1);
         e = e + 1;
         cycles = 1;
      end else if (p == 30) begin
         n = m;
         cycles = 1;
      end else begin
         k = 0;
         while (p + 8 * k < 22) k++;
         n = m << (30 - p);
         e = e - (30 - p);
         cycles = k + (30 - (p + 8 * k)) + 1;
      end
      sig = int'(n[30:7]);
      if (RNE && n[6] && ((n[5:0] != 6'd0) || n[7])) sig = sig + 1;
      if (sig == (1 << 24)) begin
         sig = 1 << 23;
         e = e + 1;
      end
      eb = e[7:0];
      if (e >= 255)     f = {s, 8'hFF, 23'd0};
      else if (e <= 0)  f = {s, 31'd0};
      else              f = {s, eb, sig[22:0]};
      lat = cycles + 2;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the transfer-out edge.
   task automatic applyStimulus(input string tag, input logic [31:0] m, input logic [31:0] b,
                                input logic [31:0] expF, input int expLat, input int hold);
      int lat;
      checkOutput({tag, ".inReady"}, {31'd0, in_ready}, 32'd1);
      out_ready = (hold == 0);
      in_m = m;
      in_b = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_m = $urandom;
      in_b = $urandom;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput({tag, ".outValid"}, {31'd0, out_valid}, 32'd1);
      checkOutput({tag, ".latency"}, lat, expLat);
      checkOutput({tag, ".outF"}, out_f, expF);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         in_m = $urandom;
         in_b = $urandom;
         @(posedge clk); #1;
         checkOutput({tag, ".holdF"}, out_f, expF);
         checkOutput({tag, ".holdRdyVld"}, {30'd0, in_ready, out_valid}, 32'd1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput({tag, ".release"}, {30'd0, in_ready, out_valid}, 32'd2);
   endtask

   initial begin
      logic [31:0] rm;
      logic [31:0] rb;
      logic [31:0] expF;
      int          expLat;
      int          sawValid;

      #2;
      checkOutput("reset.inReady", {31'd0, in_ready}, 32'd1);
      checkOutput("reset.outValid", {31'd0, out_valid}, 32'd0);
      checkOutput("reset.outF", out_f, 32'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      applyStimulus("one", 32'h4000_0000, mkB(0, 8'h7F, 0, 0), 32'h3F80_0000, 3, 0);
      applyStimulus("ovf31", 32'h8000_0000, mkB(0, 8'h7F, 0, 0), 32'h4000_0000, 3, 0);
      applyStimulus("expInf", 32'h8000_0000, mkB(0, 8'hFE, 0, 0), 32'h7F80_0000, 3, 0);
      applyStimulus("flush", 32'h2000_0000, mkB(0, 8'h01, 0, 0), 32'h0000_0000, 4, 0);
      applyStimulus("deepNorm", 32'h0000_0080, mkB(0, 8'h7F, 0, 0), 32'h3400_0000, 12, 0);
`ifdef RELM_FPNORM_ROUND_EN
      applyStimulus("rneUp", 32'h4000_00C0, mkB(0, 8'h7F, 0, 0), 32'h3F80_0002, 3, 0);
      applyStimulus("rneTie", 32'h4000_0040, mkB(0, 8'h7F, 0, 0), 32'h3F80_0000, 3, 0);
      applyStimulus("carry", 32'h7FFF_FFC0, mkB(0, 8'h7F, 0, 0), 32'h4000_0000, 3, 0);
`else
      applyStimulus("truncUp", 32'h4000_00C0, mkB(0, 8'h7F, 0, 0), 32'h3F80_0001, 3, 0);
      applyStimulus("truncTie", 32'h4000_0040, mkB(0, 8'h7F, 0, 0), 32'h3F80_0000, 3, 0);
      applyStimulus("carry", 32'h7FFF_FFC0, mkB(0, 8'h7F, 0, 0), 32'h3FFF_FFFF, 3, 0);
`endif
      applyStimulus("infZero", 32'h1234_5678, mkB(1, 8'h55, 1, 1), 32'hFF80_0000, 1, 5);
      applyStimulus("zeroFlag", 32'h4000_0000, mkB(1, 8'h7F, 0, 1), 32'h8000_0000, 1, 0);
      applyStimulus("zeroM", 32'h0000_0000, mkB(0, 8'h7F, 0, 0), 32'h0000_0000, 1, 0);
      applyStimulus("preRst", 32'h4000_0000, mkB(1, 8'h80, 0, 0), 32'hC000_0000, 3, 0);

      // Abort a long normalization mid-flight with an asynchronous reset.
      in_m = 32'h0000_0001;
      in_b = mkB(0, 8'h7F, 0, 0);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      checkOutput("rstNorm.outValid", {31'd0, out_valid}, 32'd0);
      checkOutput("rstNorm.outF", out_f, 32'd0);
      checkOutput("rstNorm.inReady", {31'd0, in_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      sawValid = 0;
      repeat (14) begin
         if (out_valid === 1'b1) sawValid = 1;
         @(posedge clk); #1;
      end
      checkOutput("rstNorm.noPulse", sawValid, 0);
      applyStimulus("postRst", 32'h4000_0000, mkB(0, 8'h7F, 0, 0), 32'h3F80_0000, 3, 0);

      for (int i = 0; i < 200; i++) begin
         rm = $urandom >> $urandom_range(0, 31);
         rb = $urandom;
         rb[22] = ($urandom_range(0, 15) == 0);
         rb[21] = ($urandom_range(0, 15) == 0);
         refModel(rm, rb, expF, expLat);
         applyStimulus("rand", rm, rb, expF, expLat, $urandom_range(0, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
